// File: rtl/traffic_pkg.sv
// Shared state encoding for the request/green handshake.
// Used by call_detector and by trafficlight monitors.
package traffic_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CALLED  = 2'd1;
  localparam logic [1:0] ST_SERVING = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_CALLED  = ST_CALLED,
    S_SERVING = ST_SERVING,
    S_DONE    = ST_DONE
  } state_e;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer followed by a stability counter.
// The filtered level flips only after DEBOUNCE_CYCLES equal differing samples.
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sense_in,
  output logic detected
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          det_q;
  logic          det_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count consecutive samples that disagree with the filtered level.
  always_comb begin
    det_d = det_q;
    cnt_d = '0;
    if (sync2_q != det_q) begin
      if (cnt_q == CNT_LAST) begin
        det_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and filter state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      det_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sense_in;
      sync2_q <= sync1_q;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
    end
  end

  assign detected = det_q;

endmodule

// File: rtl/call_detector.sv
// Demand front-end for one signal head: conditions a button or loop
// and drives request until served, gapped out or maxed out.
module call_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 8,
  parameter int MAX_HOLD_CYCLES = 64,
  parameter bit LATCHING        = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sense_in,
  input  logic green,
  output logic request,
  output logic wait_lamp,
  output logic detected
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int HW = $clog2(MAX_HOLD_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD_CYCLES - 1);

  logic          det;
  logic          det_prev_q;
  logic          evt;
  logic          press;
  state_e        state_q;
  state_e        state_d;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_d;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          pend_q;
  logic          pend_d;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filter (
    .clock   (clock),
    .reset_n (reset_n),
    .sense_in(sense_in),
    .detected(det)
  );

  // A button registers on the filtered rising edge; a loop on its level.
  assign evt   = LATCHING ? (det & ~det_prev_q) : det;
  assign press = LATCHING & evt;

  // Next state, timers and the pending-call flag.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        if (evt) begin
          if (green) begin
            state_d = S_SERVING;
            gap_d   = GAP_LOAD;
            hold_d  = '0;
          end else begin
            state_d = S_CALLED;
          end
        end
      end
      S_CALLED: begin
        pend_d = 1'b0;
        if (green) begin
          state_d = S_SERVING;
          gap_d   = GAP_LOAD;
          hold_d  = '0;
        end else if (!LATCHING && !det) begin
          state_d = S_IDLE;
        end
      end
      S_SERVING: begin
        if (hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
        if (det) begin
          gap_d = GAP_LOAD;
        end else if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end
        if (press) pend_d = 1'b1;
        if (!green) begin
          pend_d  = 1'b0;
          state_d = (det || pend_q || press) ? S_CALLED : S_IDLE;
        end else if (gap_d == '0 || hold_q == HOLD_LAST) begin
          pend_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (press) pend_d = 1'b1;
        if (!green) begin
          pend_d = 1'b0;
          if (pend_q || press || (!LATCHING && det)) begin
            state_d = S_CALLED;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, timer and edge-detect registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      gap_q      <= '0;
      hold_q     <= '0;
      pend_q     <= 1'b0;
      det_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      det_prev_q <= det;
    end
  end

  assign request   = (state_q == S_CALLED) || (state_q == S_SERVING);
  assign wait_lamp = (state_q == S_CALLED);
  assign detected  = det;

endmodule

// File: tb/tb_call_detector.sv
// Directed bench: one latching (button) and one non-latching (loop)
// instance, driven through reset, debounce, gap-out, max-out, preemption.
module tb_call_detector;
  import traffic_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic s1 = 1'b0;
  logic g1 = 1'b0;
  logic s0 = 1'b0;
  logic g0 = 1'b0;
  logic r1, w1, d1;
  logic r0, w0, d0;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  call_detector #(
    .DEBOUNCE_CYCLES(4),
    .GAP_CYCLES(8),
    .MAX_HOLD_CYCLES(64),
    .LATCHING(1'b1)
  ) u1 (
    .clock(clock),
    .reset_n(reset_n),
    .sense_in(s1),
    .green(g1),
    .request(r1),
    .wait_lamp(w1),
    .detected(d1)
  );

  call_detector #(
    .DEBOUNCE_CYCLES(4),
    .GAP_CYCLES(8),
    .MAX_HOLD_CYCLES(64),
    .LATCHING(1'b0)
  ) u0 (
    .clock(clock),
    .reset_n(reset_n),
    .sense_in(s0),
    .green(g0),
    .request(r0),
    .wait_lamp(w0),
    .detected(d0)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Press and release the button; leaves the filter idle again.
  task automatic press_u1();
    s1 = 1'b1;
    repeat (7) tick();
    s1 = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    // 1: reset held, inputs busy
    g1 = 1'b1;
    g0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s1 = ~s1;
      s0 = ~s0;
      tick();
      chk("rst_req1", {31'd0, r1}, 32'd0);
      chk("rst_req0", {31'd0, r0}, 32'd0);
      chk("rst_flags", {30'd0, w1 | w0, d1 | d0}, 32'd0);
    end
    s1 = 1'b0;
    s0 = 1'b0;
    reset_n = 1'b1;
    repeat (4) tick();
    chk("idle_st1", 32'(u1.state_q), 32'(ST_IDLE));
    chk("idle_st0", 32'(u0.state_q), 32'(ST_IDLE));
    chk("unreq_green", {31'd0, r1 | r0}, 32'd0);
    g1 = 1'b0;
    g0 = 1'b0;
    tick();

    // 3: three-cycle glitch never qualifies
    s1 = 1'b1;
    repeat (3) tick();
    s1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("glitch", {30'd0, d1, r1}, 32'd0);
    end

    // 2: latency from sense_in to detected and request
    s1 = 1'b1;
    repeat (5) tick();
    chk("det_e5", {31'd0, d1}, 32'd0);
    tick();
    chk("det_e6", {31'd0, d1}, 32'd1);
    chk("req_e6", {31'd0, r1}, 32'd0);
    tick();
    chk("req_e7", {30'd0, r1, w1}, 32'd3);
    s1 = 1'b0;
    repeat (8) tick();
    chk("latched", {30'd0, r1, w1}, 32'd3);
    chk("det_fell", {31'd0, d1}, 32'd0);

    // 4: gap-out with no presence
    g1 = 1'b1;
    tick();
    chk("srv_t1", {30'd0, r1, w1}, 32'd2);
    chk("srv_st", 32'(u1.state_q), 32'(ST_SERVING));
    repeat (7) tick();
    chk("gap_t8", {31'd0, r1}, 32'd1);
    tick();
    chk("gap_t9", {31'd0, r1}, 32'd0);
    chk("done_st", 32'(u1.state_q), 32'(ST_DONE));
    repeat (3) tick();
    chk("done_hold", {31'd0, r1}, 32'd0);
    g1 = 1'b0;
    tick();
    chk("done_idle", 32'(u1.state_q), 32'(ST_IDLE));

    // 6a: preempted service, no presence
    press_u1();
    chk("call2", 32'(u1.state_q), 32'(ST_CALLED));
    g1 = 1'b1;
    repeat (4) tick();
    chk("pre_srv", 32'(u1.state_q), 32'(ST_SERVING));
    g1 = 1'b0;
    tick();
    chk("pre_idle", 32'(u1.state_q), 32'(ST_IDLE));
    chk("pre_req", {31'd0, r1}, 32'd0);

    // 6b: press while DONE re-calls after green falls
    press_u1();
    g1 = 1'b1;
    repeat (9) tick();
    chk("done2", 32'(u1.state_q), 32'(ST_DONE));
    s1 = 1'b1;
    repeat (7) tick();
    chk("done_press", 32'(u1.state_q), 32'(ST_DONE));
    chk("done_preq", {31'd0, r1}, 32'd0);
    s1 = 1'b0;
    g1 = 1'b0;
    tick();
    chk("recall", {30'd0, r1, w1}, 32'd3);

    // 5: loop presence held through green -> max-out
    s0 = 1'b1;
    repeat (7) tick();
    chk("loop_req", {30'd0, r0, w0}, 32'd3);
    g0 = 1'b1;
    tick();
    chk("loop_srv", 32'(u0.state_q), 32'(ST_SERVING));
    repeat (63) tick();
    chk("max_63", {31'd0, r0}, 32'd1);
    tick();
    chk("max_64", {31'd0, r0}, 32'd0);
    chk("max_st", 32'(u0.state_q), 32'(ST_DONE));
    g0 = 1'b0;
    tick();
    chk("max_recall", {30'd0, r0, w0}, 32'd3);

    // Vehicle leaves before service
    s0 = 1'b0;
    repeat (6) tick();
    chk("leave_e6", {31'd0, r0}, 32'd1);
    tick();
    chk("leave_e7", {31'd0, r0}, 32'd0);
    chk("leave_st", 32'(u0.state_q), 32'(ST_IDLE));

    // Reset mid-call drops request without a clock edge
    s0 = 1'b1;
    repeat (7) tick();
    chk("pre_rst", {31'd0, r0}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst", {30'd0, r0, r1}, 32'd0);
    s0 = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
